// File: rtl/mips_alu_pkg.sv
// Shared opcode encodings and EX-stage FSM state type for the MIPS ALU/MDU block.
package mips_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_MFHI  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SLTU  = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_MULT  = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;
  localparam logic [3:0] OP_NOR   = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_SLL   = 4'd14;
  localparam logic [3:0] OP_SRL   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_mdu_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_mdu.sv
// Iterative multiply/divide datapath: shift-add multiply or restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up applied on the last step.
module mips_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q, opnd_q, a_raw_q;
  logic               div_q, neg_q, neg_rem_q, div0_q;

  logic [WIDTH-1:0]   a_mag_s, b_mag_s, hi_d, lo_d;
  logic [WIDTH:0]     sum_s, shifted_s, trial_s;
  logic [2*WIDTH-1:0] prod_s;

  // Operand magnitudes, one iteration step, and the signed final result.
  always_comb begin
    a_mag_s   = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag_s   = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    // Multiply: hi accumulates multiplicand when the multiplier LSB is set, then {hi,lo} shifts right.
    sum_s     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    // Divide: remainder:quotient shifts left, subtract divisor, restore when negative.
    shifted_s = {hi_q, lo_q[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, opnd_q};
    if (div_q) begin
      hi_d = trial_s[WIDTH] ? shifted_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ~trial_s[WIDTH]};
    end else begin
      hi_d = sum_s[WIDTH:1];
      lo_d = {sum_s[0], lo_q[WIDTH-1:1]};
    end
    prod_s = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    if (!div_q) begin
      hi_o = prod_s[2*WIDTH-1:WIDTH];
      lo_o = prod_s[WIDTH-1:0];
    end else if (div0_q) begin
      hi_o = a_raw_q;
      lo_o = {WIDTH{1'b1}};
    end else begin
      hi_o = neg_rem_q ? -hi_d : hi_d;
      lo_o = neg_q ? -lo_d : lo_d;
    end
    done_o = (cnt_q == CW'(1));
  end

  // Operand latch on start, then one step per cycle until the counter empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else if (start_i) begin
      cnt_q     <= CW'(WIDTH);
      hi_q      <= '0;
      lo_q      <= a_mag_s;
      opnd_q    <= b_mag_s;
      a_raw_q   <= a_i;
      div_q     <= div_i;
      neg_q     <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      neg_rem_q <= signed_i && a_i[WIDTH-1];
      div0_q    <= (b_i == '0);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: rtl/mips_alu_mdu.sv
// EX-stage MIPS ALU with registered result, valid/ready handshake and an
// iterative MDU writing HI/LO.
module mips_alu_mdu
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Ovf,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q;
  logic             out_valid_q, zero_q, ovf_q, busy_q;
  logic [WIDTH-1:0] alu_out_q, hi_q, lo_q;

  logic             accept_s, mdu_op_s, mdu_start_s, mdu_signed_s, mdu_div_s, mdu_done_s;
  logic             ovf_s;
  logic [WIDTH-1:0] res_s, sum_s, diff_s, mdu_hi_s, mdu_lo_s;

  // Handshake decode and single-cycle ALU result.
  always_comb begin
    in_ready     = (state_q == ST_IDLE) && !(out_valid_q && !out_ready);
    accept_s     = in_valid && in_ready;
    mdu_op_s     = is_mdu_op(ALUctl);
    mdu_start_s  = accept_s && mdu_op_s;
    mdu_signed_s = (ALUctl == OP_MULT) || (ALUctl == OP_DIV);
    mdu_div_s    = (ALUctl == OP_DIVU) || (ALUctl == OP_DIV);
    sum_s        = A + B;
    diff_s       = A - B;
    res_s        = '0;
    ovf_s        = 1'b0;
    case (ALUctl)
      OP_AND:  res_s = A & B;
      OP_OR:   res_s = A | B;
      OP_XOR:  res_s = A ^ B;
      OP_NOR:  res_s = ~(A | B);
      OP_ADD: begin
        res_s = sum_s;
        ovf_s = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res_s = diff_s;
        ovf_s = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  res_s = B << A[SHW-1:0];
      OP_SRL:  res_s = B >> A[SHW-1:0];
      OP_MFHI: res_s = hi_q;
      OP_MFLO: res_s = lo_q;
      default: res_s = '0;
    endcase
  end

  mips_mdu #(.WIDTH(WIDTH)) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mdu_start_s),
    .signed_i (mdu_signed_s),
    .div_i    (mdu_div_s),
    .a_i      (A),
    .b_i      (B),
    .done_o   (mdu_done_s),
    .hi_o     (mdu_hi_s),
    .lo_o     (mdu_lo_s)
  );

  // Control FSM with registered result, flags, HI/LO and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      alu_out_q   <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      // A consumed result drops unless a new one loads below in the same cycle.
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            if (mdu_op_s) begin
              state_q <= mdu_div_s ? ST_DIV : ST_MUL;
              busy_q  <= 1'b1;
            end else begin
              alu_out_q   <= res_s;
              zero_q      <= (res_s == '0);
              ovf_q       <= ovf_s;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (mdu_done_s) begin
            hi_q        <= mdu_hi_s;
            lo_q        <= mdu_lo_s;
            alu_out_q   <= mdu_lo_s;
            zero_q      <= (mdu_lo_s == '0);
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign ALUOut    = alu_out_q;
  assign Zero      = zero_q;
  assign Ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mips_alu_mdu.sv
// Randomised and directed bench for mips_alu_mdu at WIDTH=32 and WIDTH=16,
// compared against an arithmetic reference model of the instruction set.
module tb_mips_alu_mdu;
  import mips_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vld0, rdy0, ovld0, ordy0, zero0, ovf0, busy0;
  logic        vld1, rdy1, ovld1, ordy1, zero1, ovf1, busy1;
  logic [3:0]  ctl0, ctl1;
  logic [31:0] a0, b0, out0;
  logic [15:0] a1, b1, out1;

  int     n_checks = 0;
  int     n_errors = 0;
  longint hi_m [2];
  longint lo_m [2];

  mips_alu_mdu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld0), .in_ready(rdy0), .ALUctl(ctl0),
    .A(a0), .B(b0), .out_valid(ovld0), .out_ready(ordy0), .ALUOut(out0),
    .Zero(zero0), .Ovf(ovf0), .busy(busy0)
  );

  mips_alu_mdu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld1), .in_ready(rdy1), .ALUctl(ctl1),
    .A(a1), .B(b1), .out_valid(ovld1), .out_ready(ordy1), .ALUOut(out1),
    .Zero(zero1), .Ovf(ovf1), .busy(busy1)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_rdy(input int u);  return (u != 0) ? rdy1  : rdy0;  endfunction
  function automatic logic get_vld(input int u);  return (u != 0) ? ovld1 : ovld0; endfunction
  function automatic logic get_busy(input int u); return (u != 0) ? busy1 : busy0; endfunction
  function automatic logic get_zero(input int u); return (u != 0) ? zero1 : zero0; endfunction
  function automatic logic get_ovf(input int u);  return (u != 0) ? ovf1  : ovf0;  endfunction
  function automatic longint get_out(input int u);
    return (u != 0) ? longint'(out1) : longint'(out0);
  endfunction

  task automatic drive(input int u, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic ordy);
    if (u == 0) begin
      vld0 = v; ctl0 = op; a0 = a; b0 = b; ordy0 = ordy;
    end else begin
      vld1 = v; ctl1 = op; a1 = a[15:0]; b1 = b[15:0]; ordy1 = ordy;
    end
  endtask

  // Reference: ISA semantics computed on plain 64-bit integers.
  task automatic model(input int u, input logic [3:0] op, input longint a_in, input longint b_in,
                       output longint res, output logic ovf);
    int     w;
    longint mask, mx, mn, a, b, sa, sb, p;
    w    = (u != 0) ? 16 : 32;
    mask = (longint'(1) << w) - 1;
    mx   = (longint'(1) << (w - 1)) - 1;
    mn   = -(mx + 1);
    a    = a_in & mask;
    b    = b_in & mask;
    sa   = (a > mx) ? a - (mask + 1) : a;
    sb   = (b > mx) ? b - (mask + 1) : b;
    res  = 0;
    ovf  = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b) & mask;
      OP_ADD:  begin p = sa + sb; res = p & mask; ovf = (p > mx) || (p < mn); end
      OP_SUB:  begin p = sa - sb; res = p & mask; ovf = (p > mx) || (p < mn); end
      OP_SLT:  res = (sa < sb) ? 1 : 0;
      OP_SLTU: res = (a < b) ? 1 : 0;
      OP_SLL:  res = (b << (a % w)) & mask;
      OP_SRL:  res = b >> (a % w);
      OP_MFHI: res = hi_m[u];
      OP_MFLO: res = lo_m[u];
      OP_MULTU: begin p = a * b;   hi_m[u] = (p >> w) & mask; lo_m[u] = p & mask; res = lo_m[u]; end
      OP_MULT:  begin p = sa * sb; hi_m[u] = (p >> w) & mask; lo_m[u] = p & mask; res = lo_m[u]; end
      OP_DIVU, OP_DIV: begin
        if (b == 0) begin
          lo_m[u] = mask;
          hi_m[u] = a;
        end else if (op == OP_DIVU) begin
          lo_m[u] = a / b;
          hi_m[u] = a % b;
        end else begin
          lo_m[u] = (sa / sb) & mask;
          hi_m[u] = (sa % sb) & mask;
        end
        res = lo_m[u];
      end
      default: res = 0;
    endcase
  endtask

  task automatic wait_ready(input int u, input string tag);
    int guard = 0;
    while (!get_rdy(u) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic run_op(input int u, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    longint er;
    logic   eo, rdy_seen, mdu;
    int     w, lat, bcnt;
    w   = (u != 0) ? 16 : 32;
    mdu = is_mdu_op(op);
    model(u, op, longint'(a), longint'(b), er, eo);
    @(negedge clk);
    wait_ready(u, tag);
    drive(u, 1'b1, op, a, b, 1'b1);
    @(negedge clk);
    drive(u, 1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom, 1'b1);
    lat = 1; bcnt = 0; rdy_seen = 1'b0;
    while (!get_vld(u) && lat <= 40) begin
      bcnt += int'(get_busy(u));
      rdy_seen |= get_rdy(u);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, mdu ? w + 1 : 1);
    chk({tag, "_result"}, get_out(u), er);
    chk({tag, "_zero"}, get_zero(u), (er == 0) ? 1 : 0);
    chk({tag, "_ovf"}, get_ovf(u), eo);
    if (mdu) begin
      chk({tag, "_busy_cycles"}, bcnt, w);
      chk({tag, "_ready_while_busy"}, rdy_seen, 0);
      chk({tag, "_busy_at_result"}, get_busy(u), 0);
    end
  endtask

  task automatic backpressure();
    longint r1, r2, r3;
    logic   o;
    model(0, OP_ADD, 64'h12345678, 64'h11111111, r1, o);
    model(0, OP_XOR, 64'h0F0F0F0F, 64'hFFFF0000, r2, o);
    model(0, OP_OR,  64'h00000001, 64'h80000000, r3, o);
    @(negedge clk);
    wait_ready(0, "bp");
    drive(0, 1'b1, OP_ADD, 32'h12345678, 32'h11111111, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, OP_AND, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_value", get_out(0), r1);
      chk("bp_hold_valid", ovld0, 1);
      chk("bp_hold_ready", rdy0, 0);
      if (i < 2) @(negedge clk);
    end
    drive(0, 1'b1, OP_XOR, 32'h0F0F0F0F, 32'hFFFF0000, 1'b1);
    #1;
    chk("bp_release_ready", rdy0, 1);
    @(negedge clk);
    chk("bp_r2", get_out(0), r2);
    chk("bp_r2_valid", ovld0, 1);
    drive(0, 1'b1, OP_OR, 32'h00000001, 32'h80000000, 1'b1);
    @(negedge clk);
    chk("bp_r3", get_out(0), r3);
    chk("bp_r3_valid", ovld0, 1);
    drive(0, 1'b0, OP_AND, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("bp_drained", ovld0, 0);
  endtask

  task automatic reset_mid_multu();
    @(negedge clk);
    wait_ready(0, "rst");
    drive(0, 1'b1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, OP_AND, 32'h0, 32'h0, 1'b1);
    repeat (9) @(negedge clk);
    chk("rst_busy_before", busy0, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", ovld0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_aluout", get_out(0), 0);
    chk("rst_zero", zero0, 1);
    chk("rst_ovf", ovf0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hi_m[0] = 0; lo_m[0] = 0; hi_m[1] = 0; lo_m[1] = 0;
    #1;
    chk("rst_ready_after", rdy0, 1);
    repeat (36) @(negedge clk);
    chk("rst_no_late_result", ovld0, 0);
    run_op(0, OP_MFHI, 32'h0, 32'h0, "rst_mfhi");
    run_op(0, OP_MFLO, 32'h0, 32'h0, "rst_mflo");
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'hFFFFFFFF;
      2:       v = 32'h1 << (w - 1);
      3:       v = 32'($urandom_range(0, 9));
      4:       v = 32'h1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    hi_m[0] = 0; lo_m[0] = 0; hi_m[1] = 0; lo_m[1] = 0;
    drive(0, 1'b0, OP_AND, 32'h0, 32'h0, 1'b1);
    drive(1, 1'b0, OP_AND, 32'h0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset_out_valid", get_vld(u), 0);
      chk("reset_busy", get_busy(u), 0);
      chk("reset_aluout", get_out(u), 0);
      chk("reset_zero", get_zero(u), 1);
      chk("reset_ovf", get_ovf(u), 0);
    end
    rst_n = 1'b1;

    run_op(0, OP_ADD,  32'h7FFFFFFF, 32'h1, "add32_ovf");
    run_op(0, OP_SUB,  32'h5, 32'h5, "sub32_zero");
    run_op(0, OP_SUB,  32'h80000000, 32'h1, "sub32_ovf");
    run_op(0, OP_SLT,  32'hFFFFFFFF, 32'h1, "slt32");
    run_op(0, OP_SLTU, 32'hFFFFFFFF, 32'h1, "sltu32");
    run_op(0, OP_SLL,  32'h4, 32'h1, "sll32");
    run_op(0, OP_SRL,  32'h1F, 32'h80000000, "srl32");
    run_op(0, OP_NOR,  32'h0, 32'h0, "nor32");
    run_op(0, OP_MULT, 32'hFFFFFFFD, 32'h7, "mult32");
    run_op(0, OP_MFHI, 32'h0, 32'h0, "mfhi32_mult");
    run_op(0, OP_DIV,  32'hFFFFFFF9, 32'h2, "div32");
    run_op(0, OP_MFHI, 32'h0, 32'h0, "mfhi32_div");
    run_op(0, OP_DIVU, 32'h9, 32'h0, "divu32_by0");
    run_op(0, OP_MFHI, 32'h0, 32'h0, "mfhi32_by0");
    run_op(0, OP_DIV,  32'h80000000, 32'hFFFFFFFF, "div32_min");
    run_op(0, OP_MFHI, 32'h0, 32'h0, "mfhi32_min");
    run_op(0, OP_ADD,  32'h1, 32'h2, "add32_pre_bp");
    backpressure();

    run_op(1, OP_ADD,   32'h7FFF, 32'h1, "add16_ovf");
    run_op(1, OP_MULTU, 32'hFFFF, 32'hFFFF, "multu16");
    run_op(1, OP_MFHI,  32'h0, 32'h0, "mfhi16");
    run_op(1, OP_DIV,   32'hFFF9, 32'h2, "div16");
    run_op(1, OP_MFHI,  32'h0, 32'h0, "mfhi16_div");
    run_op(1, OP_DIV,   32'h8000, 32'hFFFF, "div16_min");
    run_op(1, OP_DIVU,  32'h9, 32'h0, "divu16_by0");
    run_op(1, OP_MFHI,  32'h0, 32'h0, "mfhi16_by0");

    for (int n = 0; n < 80; n++) begin
      int u;
      u = n % 2;
      run_op(u, 4'($urandom_range(0, 15)), pick((u != 0) ? 16 : 32),
             pick((u != 0) ? 16 : 32), (u != 0) ? "rand16" : "rand32");
    end

    reset_mid_multu();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_alu_mdu.md
# mips_alu_mdu

Parametrised successor to the basic MIPS ALU: a registered ALU with a built-in iterative multiply/divide unit (MDU) and HI/LO registers, sitting in the EX stage of the MIPS datapath. It executes the full R-type ALU op set in one cycle and MULT/MULTU/DIV/DIVU in WIDTH+1 cycles. A valid/ready handshake on input and output lets the pipeline stall while the MDU is busy.

## Interface
- WIDTH, 32, operand/result width (≥8, even)
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept an operation this cycle
- ALUctl  in  4  operation code (see Operation)
- A, B  in  WIDTH  operands
- out_valid  out  1  ALUOut/Zero/Ovf hold a result
- out_ready  in  1  consumer takes result this cycle
- ALUOut  out  WIDTH  result
- Zero  out  1  ALUOut == 0
- Ovf  out  1  signed overflow (ADD/SUB only, else 0)
- busy  out  1  MDU iterating

## Operation
- Encoding: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 MFHI, 5 MFLO, 6 SUB, 7 SLT (signed), 8 SLTU, 9 MULTU, 10 MULT, 11 DIVU, 12 NOR, 13 DIV, 14 SLL (B << A[SHW-1:0]), 15 SRL (B >> A[SHW-1:0]).
- ADD/SUB modulo 2^WIDTH; Ovf = operand signs equal (ADD) / differ (SUB) and result sign differs from A.
- SLT/SLTU: result 1 or 0, zero-extended.
- States: IDLE, MUL, DIV, DONE.
- IDLE + accept of a single-cycle op: result registered, out_valid set, stay IDLE.
- IDLE + accept of MULT/MULTU: latch magnitudes (signed ops use |A|,|B| and record result sign), count = WIDTH, go to MUL; one shift-add step per cycle.
- IDLE + accept of DIV/DIVU: same, restoring division one bit per cycle, go to DIV.
- MUL/DIV when count reaches 0: apply sign correction, write {HI,LO} (MUL: HI=upper, LO=lower; DIV: LO=quotient, HI=remainder, remainder sign = dividend sign), ALUOut=LO, out_valid set, go to DONE → IDLE next cycle.
- Divide by zero: LO = all ones, HI = A; no trap. Signed MIN / −1: LO = MIN, HI = 0.
- MFHI/MFLO return the current HI/LO; HI/LO are written only by MDU ops.

## Timing
- in_ready = (state == IDLE) && !(out_valid && !out_ready).
- Accept = in_valid && in_ready; ALUctl/A/B sampled only on accept.
- Single-cycle op: out_valid the cycle after accept.
- MDU op: out_valid exactly WIDTH+1 cycles after accept; busy high from the cycle after accept until out_valid rises.
- out_valid holds, with ALUOut/Zero/Ovf stable, until out_valid && out_ready; it clears that cycle unless a new result loads in the same cycle (back-to-back single-cycle ops sustain 1/cycle).
- MFHI/MFLO issued immediately after an MDU result sees the new HI/LO.
- Reset (any cycle, including mid-MDU): state IDLE, out_valid 0, busy 0, ALUOut 0, Zero 1, Ovf 0, HI 0, LO 0; the in-flight op is discarded.
- in_valid while not ready: no effect. The source holds it.

## Structure
- Package mips_alu_pkg: ALUctl opcode localparams, state enum typedef.
- Sub-module mips_mdu: iterative multiply/divide datapath and counter (start, signed, op, A, B → done, hi, lo). The top holds ALU ops, handshake, HI/LO and output registers.

## Test plan
- WIDTH=32: ADD 0x7FFFFFFF+1 → ALUOut 0x80000000, Ovf 1, Zero 0, out_valid next cycle; SUB 5−5 → 0, Zero 1.
- SLT 0xFFFFFFFF,1 → 1; SLTU same → 0; SLL A=4,B=1 → 16; NOR 0,0 → 0xFFFFFFFF.
- MULT −3×7 → busy 32 cycles, out_valid at 33, HI 0xFFFFFFFF, LO 0xFFFFFFEB; then MFHI → 0xFFFFFFFF; in_ready low throughout.
- DIV −7/2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF; DIVU 9/0 → LO 0xFFFFFFFF, HI 9; DIV 0x80000000/−1 → LO 0x80000000, HI 0.
- Back-pressure: out_ready 0 for 3 cycles after ADD → ALUOut stable, in_ready 0; then release with a new op the same cycle → 1 result/cycle.
- Assert rst_n low at cycle 10 of MULTU → out_valid 0, HI/LO 0, in_ready 1 after release; repeat the suite with WIDTH=16 (MULTU 0xFFFF×0xFFFF → HI 0xFFFE, LO 0x0001, latency 17).
